// File: rtl/ca_row_if.sv
// Bundle of the step/control inputs and the image-memory write port of the
// cellular-automaton row engine.
interface ca_row_if #(
    parameter int WIDTH = 80,
    parameter int ROWW  = 7,
    parameter int GENW  = 16
);
    logic             tick;
    logic             restart;
    logic [WIDTH-1:0] seed_in;
    logic [7:0]       rule_in;
    logic             rule_load;
    logic             mode_wrap;
    logic             mode_hold;
    logic             wr_ready;
    logic             wr_en;
    logic [ROWW-1:0]  wr_row;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             frame_done;
    logic             overrun;
    logic [GENW-1:0]  gen_count;

    // Engine side
    modport master (
        input  tick, restart, seed_in, rule_in, rule_load, mode_wrap, mode_hold, wr_ready,
        output wr_en, wr_row, wr_data, busy, frame_done, overrun, gen_count
    );

    // Controller / memory side
    modport slave (
        output tick, restart, seed_in, rule_in, rule_load, mode_wrap, mode_hold, wr_ready,
        input  wr_en, wr_row, wr_data, busy, frame_done, overrun, gen_count
    );
endinterface

// File: rtl/ca_row_engine.sv
// Elementary cellular-automaton row generator: evolves one row per step tick
// and streams each generation to the frame image memory.
module ca_row_engine #(
    parameter int          WIDTH        = 80,
    parameter int          ROWS         = 60,
    parameter int          FIRST_ROW    = 1,
    parameter int          ROWW         = 7,
    parameter logic [7:0]  DEFAULT_RULE = 8'd126,
    parameter int          GENW         = 16
) (
    input  logic      clk,
    input  logic      rst,
    ca_row_if.master  bus
);
    typedef enum logic [2:0] {S_SEED, S_WRITE, S_WAIT, S_STEP, S_HOLD} state_t;

    localparam logic [ROWW-1:0] FIRST = ROWW'(FIRST_ROW);
    localparam logic [ROWW-1:0] LAST  = ROWW'(ROWS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] row_q, row_d, row_next;
    logic [ROWW-1:0]  wr_row_q, wr_row_d;
    logic [GENW-1:0]  gen_q, gen_d;
    logic [7:0]       rule_q;
    logic             pend_q, pend_d;
    logic             ovr_q, ovr_d;
    logic             fd_q, fd_d;
    logic             wr_en_q;
    logic             busy_q;
    logic             tick_busy;

    // Neighbourhood lookup; edge cells see the opposite edge or a constant 0.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        logic l, r;
        if (gi == WIDTH - 1) begin : g_l_edge
            assign l = bus.mode_wrap & row_q[0];
        end else begin : g_l_in
            assign l = row_q[gi+1];
        end
        if (gi == 0) begin : g_r_edge
            assign r = bus.mode_wrap & row_q[WIDTH-1];
        end else begin : g_r_in
            assign r = row_q[gi-1];
        end
        assign row_next[gi] = rule_q[{l, row_q[gi], r}];
    end

    assign tick_busy = bus.tick && (state_q == S_SEED || state_q == S_WRITE || state_q == S_STEP);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        wr_row_d = wr_row_q;
        gen_d    = gen_q;
        pend_d   = pend_q;
        ovr_d    = ovr_q;
        fd_d     = 1'b0;

        if (tick_busy) begin
            if (pend_q) ovr_d  = 1'b1;
            else        pend_d = 1'b1;
        end

        case (state_q)
            S_SEED: begin
                row_d    = bus.seed_in;
                wr_row_d = FIRST;
                gen_d    = '0;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                // A tick landing on the accept cycle is honoured immediately.
                if (bus.wr_ready) begin
                    if (pend_q || bus.tick) begin
                        state_d = S_STEP;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.tick) state_d = S_STEP;
            end
            S_STEP: begin
                if (wr_row_q == LAST && bus.mode_hold) begin
                    fd_d    = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    row_d   = row_next;
                    gen_d   = gen_q + 1'b1;
                    state_d = S_WRITE;
                    if (wr_row_q == LAST) begin
                        wr_row_d = FIRST;
                        fd_d     = 1'b1;
                    end else begin
                        wr_row_d = wr_row_q + 1'b1;
                    end
                end
            end
            S_HOLD: ;
            default: state_d = S_SEED;
        endcase

        if (bus.restart) begin
            state_d = S_SEED;
            pend_d  = 1'b0;
            ovr_d   = 1'b0;
            fd_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_SEED;
            row_q    <= '0;
            wr_row_q <= FIRST;
            gen_q    <= '0;
            rule_q   <= DEFAULT_RULE;
            pend_q   <= 1'b0;
            ovr_q    <= 1'b0;
            fd_q     <= 1'b0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            wr_row_q <= wr_row_d;
            gen_q    <= gen_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            fd_q     <= fd_d;
            if (bus.rule_load) rule_q <= bus.rule_in;
            wr_en_q  <= (state_d == S_WRITE);
            busy_q   <= (state_d == S_SEED || state_d == S_WRITE || state_d == S_STEP);
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_row     = wr_row_q;
    assign bus.wr_data    = row_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = fd_q;
    assign bus.overrun    = ovr_q;
    assign bus.gen_count  = gen_q;
endmodule

// File: tb/tb_ca_row_engine.sv
// Scoreboard bench for ca_row_engine: stimulus pushes expected writes, a
// monitor pops and compares them on every accepted write.
module tb_ca_row_engine;
    localparam int W = 80;

    typedef struct packed {
        logic [6:0]   row;
        logic [W-1:0] data;
        logic [15:0]  gen;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   fd_cnt = 0;
    exp_t exp_q[$];

    ca_row_if #(.WIDTH(W), .ROWW(7), .GENW(16)) bus ();

    ca_row_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int r, input logic [W-1:0] d, input int g);
        exp_t e;
        e.row  = 7'(r);
        e.data = d;
        e.gen  = 16'(g);
        exp_q.push_back(e);
    endtask

    task automatic pulse_tick();
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        cyc(1);
        bus.restart = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain_timeout: got %0d pending writes expected 0", exp_q.size());
            exp_q.delete();
        end
        cyc(1);
    endtask

    // Independent reference: explicit neighbour indices with modular wrap.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] r, input logic [7:0] rule, input bit wrap);
        logic [W-1:0] n;
        for (int i = 0; i < W; i++) begin
            int  li, ri;
            logic lb, rb;
            logic [2:0] idx;
            li = i + 1;
            ri = i - 1;
            if (li >= W) lb = wrap ? r[li - W] : 1'b0; else lb = r[li];
            if (ri < 0)  rb = wrap ? r[ri + W] : 1'b0; else rb = r[ri];
            idx  = {lb, r[i], rb};
            n[i] = rule[idx];
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.frame_done) fd_cnt++;
        if (!rst && bus.wr_en && bus.wr_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_write: got row %0d data %h expected no write", bus.wr_row, bus.wr_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("[TB] write row %0d gen %0d data %h", bus.wr_row, bus.gen_count, bus.wr_data);
                chk("wr_row", 128'(bus.wr_row), 128'(e.row));
                chk("wr_data", 128'(bus.wr_data), 128'(e.data));
                chk("gen_count", 128'(bus.gen_count), 128'(e.gen));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] one, s40, cur;
        int fd0;
        one = {{(W-1){1'b0}}, 1'b1};
        s40 = one << 40;

        bus.tick = 0; bus.restart = 0; bus.seed_in = s40; bus.rule_in = 8'd0;
        bus.rule_load = 0; bus.mode_wrap = 0; bus.mode_hold = 0; bus.wr_ready = 1;

        // Reset values
        cyc(2);
        chk("rst_wr_en", 128'(bus.wr_en), 128'(0));
        chk("rst_wr_row", 128'(bus.wr_row), 128'(1));
        chk("rst_wr_data", 128'(bus.wr_data), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_frame_done", 128'(bus.frame_done), 128'(0));
        chk("rst_overrun", 128'(bus.overrun), 128'(0));
        chk("rst_gen", 128'(bus.gen_count), 128'(0));

        // Seed then one rule-126 generation
        push(1, s40, 0);
        rst = 0;
        cyc(1);
        chk("seed_wr_en_lat", 128'(bus.wr_en), 128'(1));
        chk("seed_busy", 128'(bus.busy), 128'(1));
        drain();
        push(2, (one << 39) | (one << 40) | (one << 41), 1);
        pulse_tick();
        chk("step_wr_en_low", 128'(bus.wr_en), 128'(0));
        cyc(1);
        chk("tick_wr_en_lat", 128'(bus.wr_en), 128'(1));
        drain();

        // Rule 90, seed bit 0, wrap and zero boundaries
        bus.rule_in = 8'd90; bus.rule_load = 1; cyc(1); bus.rule_load = 0;
        bus.seed_in = one; bus.mode_wrap = 1;
        push(1, one, 0);
        pulse_restart();
        drain();
        push(2, (one << 1) | (one << 79), 1);
        pulse_tick();
        drain();
        bus.mode_wrap = 0;
        push(1, one, 0);
        pulse_restart();
        drain();
        push(2, one << 1, 1);
        pulse_tick();
        drain();

        // Back-pressure: one tick during a stalled write
        bus.seed_in = s40; bus.wr_ready = 0;
        push(1, s40, 0);
        push(2, (one << 39) | (one << 41), 1);
        pulse_restart();
        cyc(1);
        for (int k = 0; k < 5; k++) begin
            chk("stall1_wr_en", 128'(bus.wr_en), 128'(1));
            chk("stall1_wr_row", 128'(bus.wr_row), 128'(1));
            chk("stall1_wr_data", 128'(bus.wr_data), 128'(s40));
            bus.tick = (k == 1);
            cyc(1);
        end
        bus.tick = 0; bus.wr_ready = 1;
        drain();
        drain();
        chk("stall1_overrun", 128'(bus.overrun), 128'(0));

        // Back-pressure: two ticks during a stalled write
        bus.wr_ready = 0;
        push(3, (one << 38) | (one << 42), 2);
        push(4, (one << 37) | (one << 39) | (one << 41) | (one << 43), 3);
        pulse_tick();
        cyc(1);
        for (int k = 0; k < 5; k++) begin
            chk("stall2_wr_en", 128'(bus.wr_en), 128'(1));
            chk("stall2_wr_row", 128'(bus.wr_row), 128'(3));
            bus.tick = (k == 1 || k == 3);
            cyc(1);
        end
        bus.tick = 0; bus.wr_ready = 1;
        drain();
        drain();
        cyc(5);
        chk("stall2_overrun", 128'(bus.overrun), 128'(1));
        chk("stall2_no_extra", 128'(exp_q.size()), 128'(0));

        // Full frame with wrap, rule 126
        bus.rule_in = 8'd126; bus.rule_load = 1; cyc(1); bus.rule_load = 0;
        push(1, s40, 0);
        pulse_restart();
        chk("restart_overrun_clr", 128'(bus.overrun), 128'(0));
        drain();
        fd0 = fd_cnt;
        cur = s40;
        for (int k = 1; k <= 59; k++) begin
            cur = ref_next(cur, 8'd126, 1'b0);
            push((k < 59) ? k + 1 : 1, cur, k);
            pulse_tick();
            drain();
        end
        chk("frame_done_once", 128'(fd_cnt - fd0), 128'(1));
        chk("frame_gen59", 128'(bus.gen_count), 128'(59));

        // Full frame with hold
        bus.mode_hold = 1;
        push(1, s40, 0);
        pulse_restart();
        drain();
        fd0 = fd_cnt;
        cur = s40;
        for (int k = 1; k <= 58; k++) begin
            cur = ref_next(cur, 8'd126, 1'b0);
            push(k + 1, cur, k);
            pulse_tick();
            drain();
        end
        chk("hold_fd_before", 128'(fd_cnt - fd0), 128'(0));
        pulse_tick();
        cyc(3);
        chk("hold_frame_done", 128'(fd_cnt - fd0), 128'(1));
        chk("hold_busy", 128'(bus.busy), 128'(0));
        chk("hold_gen", 128'(bus.gen_count), 128'(58));
        for (int k = 0; k < 3; k++) begin
            pulse_tick();
            cyc(2);
        end
        chk("hold_overrun", 128'(bus.overrun), 128'(0));
        push(1, s40, 0);
        pulse_restart();
        drain();

        // Restart + tick during a stalled write
        bus.wr_ready = 0;
        pulse_tick();
        cyc(1);
        chk("abandon_wr_en_before", 128'(bus.wr_en), 128'(1));
        bus.restart = 1; bus.tick = 1;
        cyc(1);
        bus.restart = 0; bus.tick = 0;
        chk("abandon_wr_en_drop", 128'(bus.wr_en), 128'(0));
        chk("abandon_overrun", 128'(bus.overrun), 128'(0));
        push(1, s40, 0);
        bus.wr_ready = 1;
        drain();
        cyc(5);
        chk("abandon_no_extra", 128'(exp_q.size()), 128'(0));

        // Reset mid-frame restores the default rule
        bus.rule_in = 8'd90; bus.rule_load = 1; cyc(1); bus.rule_load = 0;
        rst = 1;
        cyc(1);
        chk("rst2_wr_en", 128'(bus.wr_en), 128'(0));
        chk("rst2_gen", 128'(bus.gen_count), 128'(0));
        push(1, s40, 0);
        rst = 0;
        drain();
        push(2, (one << 39) | (one << 40) | (one << 41), 1);
        pulse_tick();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ca_row_engine.md
Name: ca_row_engine

Overview:
- Parametrised single-clock elementary cellular-automaton generator.
- Evolves a WIDTH-cell row one generation per step strobe and writes each generation into the frame image memory through a ready/valid write port.
- Sits between the prescaler-derived step strobe and the image write port.
- Adds a runtime-loadable rule, a runtime seed, wrap or zero boundaries, wrap or hold at end of frame, write back-pressure, and overrun reporting.

Parameters:
- WIDTH, 80, cells per row (one bit per cell).
- ROWS, 60, image rows; last written row is ROWS-1.
- FIRST_ROW, 1, first row written after seed or frame wrap.
- ROWW, 7, width of the row address.
- DEFAULT_RULE, 126, rule value after reset.
- GENW, 16, width of gen_count.

Ports:
- clk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle step request.
- restart  in  1  one-cycle request to reload seed_in and restart at FIRST_ROW.
- seed_in  in  WIDTH  seed row, sampled in SEED state.
- rule_in  in  8  new Wolfram rule.
- rule_load  in  1  loads rule_in into the rule register.
- mode_wrap  in  1  1 = toroidal boundary; 0 = cells outside the row read as 0.
- mode_hold  in  1  1 = stop after row ROWS-1; 0 = wrap to FIRST_ROW and keep evolving.
- wr_ready  in  1  image memory accepts the write.
- wr_en  out  1  write valid.
- wr_row  out  ROWW  row address.
- wr_data  out  WIDTH  row contents.
- busy  out  1  high in SEED, WRITE and STEP.
- frame_done  out  1  one-cycle pulse when the row pointer wraps, or when hold is entered.
- overrun  out  1  sticky; a tick was dropped.
- gen_count  out  GENW  generations since the last seed.

Behaviour:
- Reset values:
  - wr_en=0, wr_row=FIRST_ROW, wr_data=0.
  - busy=0, frame_done=0, overrun=0, gen_count=0.
  - rule=DEFAULT_RULE, tick_pending=0.
  - State is SEED.
- States: SEED, WRITE, WAIT, STEP, HOLD.
- SEED (1 cycle):
  - row <= seed_in; wr_row <= FIRST_ROW; gen_count <= 0.
  - Next state WRITE.
- WRITE:
  - wr_en=1 with wr_data=row and wr_row stable.
  - Transfer completes in the cycle wr_en and wr_ready are both high.
  - Next state is STEP if tick_pending, else WAIT (tick_pending is cleared on entry to STEP).
  - wr_en, wr_row and wr_data must not change while wr_ready is low.
- WAIT: a tick moves to STEP in the next cycle.
- STEP (1 cycle): row <= next(row) using the rule register value of that cycle; gen_count <= gen_count+1 (wraps modulo 2^GENW).
  - If wr_row != ROWS-1: wr_row+1, next state WRITE.
  - If wr_row == ROWS-1 and mode_hold=0: wr_row <= FIRST_ROW, frame_done pulses, next state WRITE.
  - If wr_row == ROWS-1 and mode_hold=1: row unchanged, gen_count unchanged, frame_done pulses, next state HOLD.
- HOLD: ticks are ignored (no overrun); only restart or rst leaves it.
- next(row):
  - new[i] = rule[{L,C,R}] with L=row[i+1], C=row[i], R=row[i-1].
  - Out-of-range index: wraps modulo WIDTH if mode_wrap=1; reads 0 if mode_wrap=0.
  - Purely combinational; one generation per STEP.
- Tick handling:
  - A tick in SEED, WRITE or STEP sets tick_pending.
  - A tick while tick_pending=1 is dropped and sets overrun.
  - overrun clears only on rst or restart.
- rule_load: rule <= rule_in on the next edge in any state. When it coincides with STEP, STEP uses the old rule.
- restart:
  - Has priority over all other inputs in any state: next state SEED, tick_pending=0, overrun=0.
  - wr_en drops the next cycle even mid-handshake; that write is abandoned.
- rst mid-operation: all reset values on the next edge regardless of state.
- Latency:
  - From tick in WAIT: STEP occurs 1 cycle later.
  - wr_en for the new generation is asserted 2 cycles after the tick.
  - After rst deasserts: SEED, then wr_en=1 on the second cycle.

Test Plan:
- Seed bit 40 only, rule 126, mode_wrap=0, wr_ready=1, one tick:
  - First write: row 1 = seed.
  - Second write: row 2, data with bits 39,40,41 set, gen_count=1.
- rule_load with 90, seed bit 0 only, one tick:
  - mode_wrap=1: data has bits 1 and 79 set.
  - mode_wrap=0: data has bit 1 only.
- wr_ready low for 5 cycles during a write:
  - wr_en, wr_row and wr_data are stable for all 5 cycles.
  - One tick arriving then is executed right after the accept; overrun=0.
  - Two ticks arriving then: overrun=1, and exactly one extra generation is written.
- ROWS=60, FIRST_ROW=1, mode_hold=0, 59 ticks:
  - Writes go to rows 1..59, then row 1.
  - frame_done pulses once; gen_count=59.
- Same setup with mode_hold=1:
  - After row 59, frame_done pulses, the engine enters HOLD and further ticks cause no writes.
  - restart then gives a SEED write of seed_in to row 1 with gen_count=0.
- restart asserted with tick while wr_en=1 and wr_ready=0:
  - wr_en=0 the next cycle; tick dropped; overrun=0.
  - Seed write follows.
  - rst mid-frame restores rule=DEFAULT_RULE.
